// File: rtl/commit_trace_buffer_pkg.sv
// Shared types for the commit trace buffer: FSM encoding and trace entry layout.
// A trace entry is {pc, we, rd, wdata}, with wdata in the low bits.
package commit_trace_buffer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARMED = 2'b01,
      ST_POST  = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   function automatic int trace_w(input int xlen);
      return 2*xlen + 6;
   endfunction

   function automatic int wdata_lsb(input int xlen);
      return 0;
   endfunction

   function automatic int rd_lsb(input int xlen);
      return xlen;
   endfunction

   function automatic int we_bit(input int xlen);
      return xlen + 5;
   endfunction

   function automatic int pc_lsb(input int xlen);
      return xlen + 6;
   endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Bundles the commit, trigger, readout and status signals of the trace buffer.
// The master side is the retire stage plus the debug host; the slave side is the monitor.
interface commit_trace_buffer_if
   import commit_trace_buffer_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int DEPTH   = 16,
   parameter int WATCH_N = 4
);
   logic                      commit_valid;
   logic [XLEN-1:0]           commit_pc;
   logic                      commit_we;
   logic [4:0]                commit_rd;
   logic [XLEN-1:0]           commit_wdata;
   logic                      arm;
   logic                      trig_en;
   logic [XLEN-1:0]           trig_pc;
   logic                      rd_en;
   logic                      rd_valid;
   logic [trace_w(XLEN)-1:0]  rd_data;
   logic [$clog2(DEPTH):0]    count;
   logic [1:0]                state;
   logic [31:0]               retired;
   logic [WATCH_N*XLEN-1:0]   watch_regs;

   modport master (
      output commit_valid, commit_pc, commit_we, commit_rd, commit_wdata,
      output arm, trig_en, trig_pc, rd_en,
      input  rd_valid, rd_data, count, state, retired, watch_regs
   );

   modport slave (
      input  commit_valid, commit_pc, commit_we, commit_rd, commit_wdata,
      input  arm, trig_en, trig_pc, rd_en,
      output rd_valid, rd_data, count, state, retired, watch_regs
   );
endinterface

// File: rtl/commit_trace_buffer_trace_ram.sv
// Trace storage: one write port, one registered read port.
// Only the read register is reset; the array contents are don't-care until written.
module commit_trace_buffer_trace_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 70
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0]             wdata_i,
   input  logic                     re_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0]             rdata_o
);
   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     rdata_q <= '0;
      else if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-stage monitor: shadows x1..xWATCH_N, counts retirements, and records a
// PC-triggered window of commits into a circular buffer drained through rd_en.
module commit_trace_buffer
   import commit_trace_buffer_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int DEPTH     = 16,
   parameter int WATCH_N   = 4,
   parameter int POST_TRIG = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   commit_trace_buffer_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = trace_w(XLEN);
   localparam logic [AW-1:0] POST_LAST = AW'((POST_TRIG > 0) ? POST_TRIG - 1 : 0);

   state_e          state_q;
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q, post_q;
   logic [CW-1:0]   count_q;
   logic [31:0]     retired_q;
   logic [XLEN-1:0] watch_q [WATCH_N];
   logic            rd_valid_q;

   logic            capture, pop, full, trig_hit;
   logic [TW-1:0]   wentry;

   // arm wins over a same-cycle commit or pop: the window restarts clean.
   assign capture  = bus.commit_valid && !bus.arm && (state_q == ST_ARMED || state_q == ST_POST);
   assign pop      = bus.rd_en && !bus.arm && (state_q == ST_DONE) && (count_q != '0);
   assign full     = (count_q == CW'(DEPTH));
   assign trig_hit = capture && (state_q == ST_ARMED) && bus.trig_en && (bus.commit_pc == bus.trig_pc);
   assign wentry   = {bus.commit_pc, bus.commit_we, bus.commit_rd, bus.commit_wdata};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         post_q     <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         rd_valid_q <= pop;
         if (bus.arm) begin
            state_q  <= ST_ARMED;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            post_q   <= '0;
            count_q  <= '0;
         end else begin
            // capture and pop live in disjoint states, so they never collide.
            if (capture) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
               if (full) rd_ptr_q <= rd_ptr_q + 1'b1;
               else      count_q  <= count_q + 1'b1;
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + 1'b1;
               count_q  <= count_q - 1'b1;
            end
            case (state_q)
               ST_ARMED: if (trig_hit) state_q <= (POST_TRIG == 0) ? ST_DONE : ST_POST;
               ST_POST: begin
                  if (capture) begin
                     if (post_q == POST_LAST) state_q <= ST_DONE;
                     else                     post_q  <= post_q + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retired_q <= '0;
         for (int i = 0; i < WATCH_N; i++) watch_q[i] <= '0;
      end else begin
         if (bus.commit_valid) retired_q <= retired_q + 1'b1;
         // x0 never matches since entry i shadows x(i+1).
         for (int i = 0; i < WATCH_N; i++) begin
            if (bus.commit_valid && bus.commit_we && bus.commit_rd == 5'(i + 1))
               watch_q[i] <= bus.commit_wdata;
         end
      end
   end

   commit_trace_buffer_trace_ram #(.DEPTH(DEPTH), .W(TW)) u_ram (
      .clk     (clk),
      .reset   (reset),
      .we_i    (capture),
      .waddr_i (wr_ptr_q),
      .wdata_i (wentry),
      .re_i    (pop),
      .raddr_i (rd_ptr_q),
      .rdata_o (bus.rd_data)
   );

   for (genvar g = 0; g < WATCH_N; g++) begin : g_watch
      assign bus.watch_regs[g*XLEN +: XLEN] = watch_q[g];
   end

   assign bus.rd_valid = rd_valid_q;
   assign bus.count    = count_q;
   assign bus.state    = state_q;
   assign bus.retired  = retired_q;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench: ifm drives a POST_TRIG=8 instance, ifz a POST_TRIG=0 instance.
module tb_commit_trace_buffer;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   commit_trace_buffer_if #(.XLEN(32), .DEPTH(16), .WATCH_N(4)) ifm ();
   commit_trace_buffer_if #(.XLEN(32), .DEPTH(16), .WATCH_N(4)) ifz ();

   commit_trace_buffer #(.XLEN(32), .DEPTH(16), .WATCH_N(4), .POST_TRIG(8)) dut (
      .clk(clk), .reset(reset), .bus(ifm));
   commit_trace_buffer #(.XLEN(32), .DEPTH(16), .WATCH_N(4), .POST_TRIG(0)) dut0 (
      .clk(clk), .reset(reset), .bus(ifz));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      ifm.commit_valid = 0; ifm.commit_pc = '0; ifm.commit_we = 0; ifm.commit_rd = '0;
      ifm.commit_wdata = '0; ifm.arm = 0; ifm.trig_en = 0; ifm.trig_pc = '0; ifm.rd_en = 0;
      ifz.commit_valid = 0; ifz.commit_pc = '0; ifz.commit_we = 0; ifz.commit_rd = '0;
      ifz.commit_wdata = '0; ifz.arm = 0; ifz.trig_en = 0; ifz.trig_pc = '0; ifz.rd_en = 0;
   endtask

   task automatic commit(input bit z, input logic [31:0] pc, input logic we,
                         input logic [4:0] rd, input logic [31:0] wd);
      if (z) begin
         ifz.commit_valid = 1; ifz.commit_pc = pc; ifz.commit_we = we;
         ifz.commit_rd = rd; ifz.commit_wdata = wd;
      end else begin
         ifm.commit_valid = 1; ifm.commit_pc = pc; ifm.commit_we = we;
         ifm.commit_rd = rd; ifm.commit_wdata = wd;
      end
      step();
      ifm.commit_valid = 0;
      ifz.commit_valid = 0;
   endtask

   task automatic arm_pulse(input bit z);
      if (z) ifz.arm = 1; else ifm.arm = 1;
      step();
      ifm.arm = 0;
      ifz.arm = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_all();
      repeat (2) step();
      reset = 1'b0;
      step();
      n_cmp++; if (ifm.state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0h want 0", ifm.state); end
      n_cmp++; if (ifm.count !== 5'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", ifm.count); end
      n_cmp++; if (ifm.retired !== 32'd0) begin n_bad++; $display("FAIL reset_retired got %0d want 0", ifm.retired); end
      n_cmp++; if (ifm.watch_regs !== 128'd0) begin n_bad++; $display("FAIL reset_watch got %0h want 0", ifm.watch_regs); end
      n_cmp++; if (ifm.rd_valid !== 1'b0 || ifm.rd_data !== 70'd0) begin
         n_bad++; $display("FAIL reset_rd got v=%0b d=%0h want v=0 d=0", ifm.rd_valid, ifm.rd_data); end
   endtask

   task automatic test_shadow();
      commit(0, 32'h0, 1, 5'd1, 32'd5);
      commit(0, 32'h4, 1, 5'd2, 32'd7);
      commit(0, 32'h8, 1, 5'd3, 32'd12);
      commit(0, 32'hC, 1, 5'd4, 32'hFFFF_FFFF);
      commit(0, 32'h10, 1, 5'd0, 32'd9);
      commit(0, 32'h14, 1, 5'd5, 32'd3);
      n_cmp++; if (ifm.watch_regs !== {32'hFFFF_FFFF, 32'd12, 32'd7, 32'd5}) begin
         n_bad++; $display("FAIL shadow_watch got %0h want ffffffff0000000c0000000700000005", ifm.watch_regs); end
      n_cmp++; if (ifm.retired !== 32'd6) begin n_bad++; $display("FAIL shadow_retired got %0d want 6", ifm.retired); end
      n_cmp++; if (ifm.state !== 2'd0 || ifm.count !== 5'd0) begin
         n_bad++; $display("FAIL shadow_idle got st=%0h cnt=%0d want st=0 cnt=0", ifm.state, ifm.count); end
   endtask

   task automatic test_trigger_drain();
      logic [69:0] exp;
      logic [31:0] pc;
      arm_pulse(0);
      n_cmp++; if (ifm.state !== 2'd1 || ifm.count !== 5'd0) begin
         n_bad++; $display("FAIL arm_state got st=%0h cnt=%0d want st=1 cnt=0", ifm.state, ifm.count); end
      ifm.trig_en = 1; ifm.trig_pc = 32'h20;
      for (int i = 0; i <= 16; i++) begin
         pc = 32'(i * 4);
         commit(0, pc, 1, 5'd10, pc ^ 32'hA5A5_0000);
         if (pc == 32'h20) begin
            n_cmp++; if (ifm.state !== 2'd2) begin n_bad++; $display("FAIL trig_post got %0h want 2", ifm.state); end
         end
         if (pc == 32'h3C) begin
            n_cmp++; if (ifm.state !== 2'd2) begin n_bad++; $display("FAIL post_hold got %0h want 2", ifm.state); end
         end
      end
      ifm.trig_en = 0;
      n_cmp++; if (ifm.state !== 2'd3 || ifm.count !== 5'd16) begin
         n_bad++; $display("FAIL trig_done got st=%0h cnt=%0d want st=3 cnt=16", ifm.state, ifm.count); end
      n_cmp++; if (ifm.retired !== 32'd23) begin n_bad++; $display("FAIL trig_retired got %0d want 23", ifm.retired); end
      ifm.rd_en = 1;
      for (int i = 0; i < 16; i++) begin
         step();
         pc = 32'(4 + 4 * i);
         exp = {pc, 1'b1, 5'd10, pc ^ 32'hA5A5_0000};
         n_cmp++; if (ifm.rd_valid !== 1'b1 || ifm.rd_data !== exp) begin
            n_bad++; $display("FAIL drain_%0d got v=%0b d=%0h want v=1 d=%0h", i, ifm.rd_valid, ifm.rd_data, exp); end
      end
      ifm.rd_en = 0;
      step();
      n_cmp++; if (ifm.rd_valid !== 1'b0 || ifm.count !== 5'd0) begin
         n_bad++; $display("FAIL drain_end got v=%0b cnt=%0d want v=0 cnt=0", ifm.rd_valid, ifm.count); end
   endtask

   task automatic test_post_trig0();
      arm_pulse(1);
      ifz.trig_en = 1; ifz.trig_pc = 32'h100;
      commit(1, 32'h100, 1, 5'd2, 32'h55);
      n_cmp++; if (ifz.state !== 2'd3 || ifz.count !== 5'd1) begin
         n_bad++; $display("FAIL pt0_done got st=%0h cnt=%0d want st=3 cnt=1", ifz.state, ifz.count); end
      commit(1, 32'h104, 0, 5'd0, 32'h0);
      commit(1, 32'h100, 0, 5'd0, 32'h0);
      ifz.trig_en = 0;
      n_cmp++; if (ifz.count !== 5'd1 || ifz.retired !== 32'd3) begin
         n_bad++; $display("FAIL pt0_frozen got cnt=%0d ret=%0d want cnt=1 ret=3", ifz.count, ifz.retired); end
      ifz.rd_en = 1;
      step();
      ifz.rd_en = 0;
      n_cmp++; if (ifz.rd_valid !== 1'b1 || ifz.rd_data !== {32'h100, 1'b1, 5'd2, 32'h55}) begin
         n_bad++; $display("FAIL pt0_pop got v=%0b d=%0h want v=1 d=%0h", ifz.rd_valid, ifz.rd_data,
                           {32'h100, 1'b1, 5'd2, 32'h55}); end
      step();
      n_cmp++; if (ifz.rd_valid !== 1'b0 || ifz.count !== 5'd0) begin
         n_bad++; $display("FAIL pt0_pulse got v=%0b cnt=%0d want v=0 cnt=0", ifz.rd_valid, ifz.count); end
   endtask

   task automatic test_rd_en_noop();
      ifm.rd_en = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (ifm.rd_valid !== 1'b0 || ifm.count !== 5'd0 || ifm.state !== 2'd3) begin
            n_bad++; $display("FAIL noop_done_%0d got v=%0b cnt=%0d st=%0h want v=0 cnt=0 st=3",
                              i, ifm.rd_valid, ifm.count, ifm.state); end
      end
      ifm.rd_en = 0;
      arm_pulse(0);
      commit(0, 32'h80, 0, 5'd0, 32'h0);
      commit(0, 32'h84, 0, 5'd0, 32'h0);
      ifm.rd_en = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++; if (ifm.rd_valid !== 1'b0 || ifm.count !== 5'd2 || ifm.state !== 2'd1) begin
            n_bad++; $display("FAIL noop_armed_%0d got v=%0b cnt=%0d st=%0h want v=0 cnt=2 st=1",
                              i, ifm.rd_valid, ifm.count, ifm.state); end
      end
      ifm.rd_en = 0;
   endtask

   task automatic test_reset_mid_post();
      logic [31:0] pc;
      arm_pulse(0);
      ifm.trig_en = 1; ifm.trig_pc = 32'h200;
      for (int i = 0; i < 10; i++) commit(0, 32'h1F0 + 32'(4 * i), 1, 5'd3, 32'h1234);
      ifm.trig_en = 0;
      n_cmp++; if (ifm.state !== 2'd2 || ifm.count !== 5'd10) begin
         n_bad++; $display("FAIL pre_reset got st=%0h cnt=%0d want st=2 cnt=10", ifm.state, ifm.count); end
      #2 reset = 1'b1;
      #1;
      n_cmp++; if (ifm.state !== 2'd0 || ifm.count !== 5'd0 || ifm.watch_regs !== 128'd0 || ifm.retired !== 32'd0) begin
         n_bad++; $display("FAIL async_reset got st=%0h cnt=%0d w=%0h ret=%0d want all 0",
                           ifm.state, ifm.count, ifm.watch_regs, ifm.retired); end
      n_cmp++; if (ifz.state !== 2'd0) begin n_bad++; $display("FAIL async_reset_z got %0h want 0", ifz.state); end
      step();
      reset = 1'b0;
      arm_pulse(1);
      ifz.trig_en = 1; ifz.trig_pc = 32'h308;
      for (int i = 0; i < 3; i++) commit(1, 32'h300 + 32'(4 * i), 0, 5'd0, 32'h0);
      ifz.trig_en = 0;
      n_cmp++; if (ifz.state !== 2'd3 || ifz.count !== 5'd3) begin
         n_bad++; $display("FAIL rearm_done got st=%0h cnt=%0d want st=3 cnt=3", ifz.state, ifz.count); end
      ifz.rd_en = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         pc = 32'h300 + 32'(4 * i);
         n_cmp++; if (ifz.rd_valid !== 1'b1 || ifz.rd_data !== {pc, 1'b0, 5'd0, 32'd0}) begin
            n_bad++; $display("FAIL rearm_pop_%0d got v=%0b d=%0h want v=1 pc=%0h", i, ifz.rd_valid, ifz.rd_data, pc); end
      end
      step();
      ifz.rd_en = 0;
      n_cmp++; if (ifz.rd_valid !== 1'b0 || ifz.count !== 5'd0) begin
         n_bad++; $display("FAIL rearm_empty got v=%0b cnt=%0d want v=0 cnt=0", ifz.rd_valid, ifz.count); end
   endtask

   task automatic test_arm_in_done();
      ifz.trig_en = 1; ifz.trig_pc = 32'h400;
      arm_pulse(1);
      commit(1, 32'h400, 0, 5'd0, 32'h0);
      n_cmp++; if (ifz.state !== 2'd3 || ifz.count !== 5'd1) begin
         n_bad++; $display("FAIL aid_pre got st=%0h cnt=%0d want st=3 cnt=1", ifz.state, ifz.count); end
      ifz.arm = 1;
      commit(1, 32'h404, 0, 5'd0, 32'h0);
      ifz.arm = 0;
      n_cmp++; if (ifz.state !== 2'd1 || ifz.count !== 5'd0 || ifz.retired !== 32'd5) begin
         n_bad++; $display("FAIL aid_arm got st=%0h cnt=%0d ret=%0d want st=1 cnt=0 ret=5",
                           ifz.state, ifz.count, ifz.retired); end
      ifz.trig_pc = 32'h408;
      commit(1, 32'h408, 0, 5'd0, 32'h0);
      ifz.trig_en = 0;
      n_cmp++; if (ifz.state !== 2'd3 || ifz.count !== 5'd1) begin
         n_bad++; $display("FAIL aid_done got st=%0h cnt=%0d want st=3 cnt=1", ifz.state, ifz.count); end
      ifz.rd_en = 1;
      step();
      ifz.rd_en = 0;
      n_cmp++; if (ifz.rd_valid !== 1'b1 || ifz.rd_data !== {32'h408, 1'b0, 5'd0, 32'd0}) begin
         n_bad++; $display("FAIL aid_pop got v=%0b d=%0h want v=1 pc=408", ifz.rd_valid, ifz.rd_data); end
   endtask

   initial begin
      test_reset();
      test_shadow();
      test_trigger_drain();
      test_post_trig0();
      test_rd_en_noop();
      test_reset_mid_post();
      test_arm_in_done();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
